// File: rtl/res_mem_arbiter_pkg.sv
// Shared definitions for the two-port resource memory arbiter.
//   ADDR_W  : word address width of the shared memory
//   DATA_W  : data width of the shared memory
//   state_e : arbiter ownership state (IDLE, OWN0, OWN1)
package res_mem_arbiter_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

endpackage

// File: rtl/res_mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory.
// Ownership moves between requesters with lock support, tie-break against the
// last owner and a burst limit that forces handover to a waiting peer.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   req0/1, lock0/1        : transfer request / keep-ownership hold
//   wr0/1, addr0/1, wdata0/1 : per-requester transfer description
//   gnt0/1                 : transfer of that requester happens this cycle
//   rdata0/1, rvalid0/1    : registered read return, one-cycle valid pulse
//   res_wr, res_rd, res_addr, res_do, res_di : memory side
//   busy                   : arbiter is not idle
module res_mem_arbiter
   import res_mem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic              res_wr,
   output logic              res_rd,
   output logic [ADDR_W-1:0] res_addr,
   output logic [DATA_W-1:0] res_do,
   input  logic [DATA_W-1:0] res_di,
   output logic              busy
);

   localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   state_e           state;
   state_e           next_state;
   logic             last_owner;
   logic [CNT_W-1:0] burst_cnt;

   // Ownership decision. From IDLE a tie goes to whoever did not own last.
   // An owner keeps the resource while locked; otherwise it hands over
   // directly when it stops requesting, or after its burst quota while the
   // peer is waiting.
   function automatic state_e next_owner(input state_e cur,
                                         input logic r0, input logic r1,
                                         input logic l0, input logic l1,
                                         input logic burst_max,
                                         input logic last);
      state_e nxt;
      nxt = cur;
      case (cur)
         IDLE: begin
            if (r0 && r1)  nxt = last ? OWN0 : OWN1;
            else if (r0)   nxt = OWN0;
            else if (r1)   nxt = OWN1;
            else           nxt = IDLE;
         end
         OWN0: begin
            if (l0)                   nxt = OWN0;
            else if (!r0)             nxt = r1 ? OWN1 : IDLE;
            else if (r1 && burst_max) nxt = OWN1;
            else                      nxt = OWN0;
         end
         OWN1: begin
            if (l1)                   nxt = OWN1;
            else if (!r1)             nxt = r0 ? OWN0 : IDLE;
            else if (r0 && burst_max) nxt = OWN0;
            else                      nxt = OWN1;
         end
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = next_owner(state, req0, req1, lock0, lock1,
                              burst_cnt == CNT_MAX, last_owner);
   end

   // Output logic: grants and memory strobes are purely combinational so a
   // transfer happens in the same cycle its grant is visible.
   always_comb begin
      gnt0     = (state == OWN0) && req0;
      gnt1     = (state == OWN1) && req1;
      res_wr   = 1'b0;
      res_rd   = 1'b0;
      res_addr = '0;
      res_do   = '0;
      if (gnt0) begin
         res_wr   = wr0;
         res_rd   = !wr0;
         res_addr = addr0;
         res_do   = wr0 ? wdata0 : '0;
      end else if (gnt1) begin
         res_wr   = wr1;
         res_rd   = !wr1;
         res_addr = addr1;
         res_do   = wr1 ? wdata1 : '0;
      end
      busy = (state != IDLE);
   end

   // Burst counter restarts with every ownership change; it saturates so a
   // locked owner simply sits at the limit until it lets go.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         burst_cnt  <= '0;
         last_owner <= 1'b1;
      end else begin
         if (next_state != state)
            burst_cnt <= '0;
         else if ((gnt0 || gnt1) && (burst_cnt != CNT_MAX))
            burst_cnt <= burst_cnt + CNT_W'(1);

         if (next_state == OWN0 && state != OWN0) last_owner <= 1'b0;
         if (next_state == OWN1 && state != OWN1) last_owner <= 1'b1;
      end
   end

   // Read return: memory data is valid alongside the read strobe, so it is
   // captured at the end of the granted cycle and presented one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0  <= '0;
         rdata1  <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 && !wr0;
         rvalid1 <= gnt1 && !wr1;
         if (gnt0 && !wr0) rdata0 <= res_di;
         if (gnt1 && !wr1) rdata1 <= res_di;
      end
   end

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Self-checking bench for res_mem_arbiter: directed vector table, hand-written
// corner sequences and random traffic against a behavioural ownership/memory
// model.
module tb_res_mem_arbiter;

   localparam int MB = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, lock0, lock1, wr0, wr1;
   logic [13:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, res_wr, res_rd, busy;
   logic [7:0]  rdata0, rdata1, res_do, res_di;
   logic [13:0] res_addr;

   res_mem_arbiter #(.MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
      .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .res_wr(res_wr), .res_rd(res_rd), .res_addr(res_addr), .res_do(res_do),
      .res_di(res_di), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory attached to the DUT
   bit [7:0] mem [0:16383];
   always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;
   assign res_di = mem[res_addr];

   typedef struct packed {
      logic        g0, g1, wr, rd;
      logic [13:0] addr;
      logic [7:0]  dout;
      logic        busy, rv0, rv1;
      logic [7:0]  rd0, rd1;
   } obs_t;

   typedef struct {
      bit          rst;
      bit          r0, r1, l0, l1, w0, w1;
      logic [13:0] a0, a1;
      logic [7:0]  d0, d1;
      obs_t        exp;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t cur;

   // ---------------- reference model ----------------
   // owner: -1 none, else requester index; tenure: grants in current ownership
   int       m_owner, m_tenure;
   bit       m_last;
   bit       m_rv [2];
   bit [7:0] m_rd [2];
   bit [7:0] mm   [0:16383];

   task automatic model_reset();
      m_owner = -1; m_tenure = 0; m_last = 1'b1;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
   endtask

   function automatic obs_t model_exp();
      obs_t e;
      e = '0;
      e.g0 = (m_owner == 0) && req0;
      e.g1 = (m_owner == 1) && req1;
      if (e.g0) begin
         e.wr = wr0; e.rd = !wr0; e.addr = addr0; e.dout = wr0 ? wdata0 : 8'h00;
      end else if (e.g1) begin
         e.wr = wr1; e.rd = !wr1; e.addr = addr1; e.dout = wr1 ? wdata1 : 8'h00;
      end
      e.busy = (m_owner != -1);
      e.rv0 = m_rv[0]; e.rv1 = m_rv[1]; e.rd0 = m_rd[0]; e.rd1 = m_rd[1];
      return e;
   endfunction

   task automatic model_step(input obs_t e);
      bit r[2], l[2], w[2], g[2];
      logic [13:0] a[2];
      logic [7:0]  d[2];
      int nxt, i, j;
      r[0] = req0; r[1] = req1; l[0] = lock0; l[1] = lock1;
      w[0] = wr0;  w[1] = wr1;  a[0] = addr0; a[1] = addr1;
      d[0] = wdata0; d[1] = wdata1; g[0] = e.g0; g[1] = e.g1;
      for (int k = 0; k < 2; k++) begin
         m_rv[k] = g[k] && !w[k];
         if (m_rv[k]) m_rd[k] = mm[a[k]];
         if (g[k] && w[k]) mm[a[k]] = d[k];
      end
      if (m_owner < 0) begin
         if (r[0] && r[1]) nxt = m_last ? 0 : 1;
         else if (r[0])    nxt = 0;
         else if (r[1])    nxt = 1;
         else              nxt = -1;
      end else begin
         i = m_owner; j = 1 - i;
         if (l[i])                               nxt = i;
         else if (!r[i])                         nxt = r[j] ? j : -1;
         else if (r[j] && m_tenure + 1 >= MB)    nxt = j;
         else                                    nxt = i;
      end
      if (nxt != m_owner) begin
         m_tenure = 0;
         if (nxt >= 0) m_last = (nxt == 1);
      end else if (g[0] || g[1]) begin
         m_tenure++;
      end
      m_owner = nxt;
   endtask

   // ---------------- helpers ----------------
   function automatic obs_t mko(bit g0, bit g1, bit wr, bit rd, logic [13:0] a,
                                logic [7:0] dout, bit bsy, bit rv0, bit rv1,
                                logic [7:0] rd0, logic [7:0] rd1);
      obs_t o;
      o.g0 = g0; o.g1 = g1; o.wr = wr; o.rd = rd; o.addr = a; o.dout = dout;
      o.busy = bsy; o.rv0 = rv0; o.rv1 = rv1; o.rd0 = rd0; o.rd1 = rd1;
      return o;
   endfunction

   function automatic vec_t mkv(bit rst, bit r0, bit r1, bit l0, bit l1, bit w0, bit w1,
                                logic [13:0] a0, logic [13:0] a1,
                                logic [7:0] d0, logic [7:0] d1, obs_t e);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.exp = e;
      return v;
   endfunction

   function automatic obs_t sample();
      return mko(gnt0, gnt1, res_wr, res_rd, res_addr, res_do, busy,
                 rvalid0, rvalid1, rdata0, rdata1);
   endfunction

   task automatic set_in(bit r0, bit r1, bit l0, bit l1, bit w0, bit w1,
                         logic [13:0] a0, logic [13:0] a1,
                         logic [7:0] d0, logic [7:0] d1);
      req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; wr0 = w0; wr1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
   endtask

   task automatic check_obs(string name, obs_t act, obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // One clock: outputs sampled mid-cycle, model advanced at the edge, inputs
   // may be changed by the caller 1 time unit after the edge.
   task automatic cyc(string name, bit use_tab, obs_t texp, bit use_model);
      obs_t e;
      @(negedge clk);
      if (!reset) model_reset();
      e   = model_exp();
      cur = sample();
      if (use_model) check_obs({name, "_model"}, cur, e);
      if (use_tab)   check_obs(name, cur, texp);
      if (cur.g0 && cur.g1) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_excl: got gnt0=1 gnt1=1 want at most one", name);
      end
      @(posedge clk);
      if (reset) model_step(e);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      set_in(0,0,0,0,0,0,0,0,0,0);
      cyc("rst", 1, '0, 0);
      reset = 1'b1;
   endtask

   vec_t tab [12];
   int   code [40];

   initial begin
      int f, n0, n1, gaps, k;
      model_reset();
      reset = 1'b0;
      set_in(0,0,0,0,0,0,0,0,0,0);
      cyc("reset_a", 1, '0, 1);
      cyc("reset_b", 1, '0, 1);
      reset = 1'b1;

      // ---- directed vector table (state carries row to row) ----
      tab[0]  = mkv(0, 1,0,0,0,1,0, 14'd5,0, 8'h01,0, mko(0,0,0,0,0,0,0,0,0,0,0));
      tab[1]  = mkv(0, 1,0,0,0,1,0, 14'd5,0, 8'h01,0, mko(1,0,1,0,14'd5,8'h01,1,0,0,0,0));
      tab[2]  = mkv(0, 1,0,0,0,0,0, 14'd5,0, 8'h00,0, mko(1,0,0,1,14'd5,8'h00,1,0,0,0,0));
      tab[3]  = mkv(0, 0,0,0,0,0,0, 0,0, 0,0,           mko(0,0,0,0,0,0,1,1,0,8'h01,0));
      tab[4]  = mkv(0, 0,0,0,0,0,0, 0,0, 0,0,           mko(0,0,0,0,0,0,0,0,0,8'h01,0));
      tab[5]  = mkv(1, 0,0,0,0,0,0, 0,0, 0,0,           mko(0,0,0,0,0,0,0,0,0,0,0));
      tab[6]  = mkv(0, 1,1,0,0,1,1, 14'h10,14'h20, 8'hA0,8'hB0, mko(0,0,0,0,0,0,0,0,0,0,0));
      tab[7]  = mkv(0, 1,1,0,0,1,1, 14'h10,14'h20, 8'hA0,8'hB0, mko(1,0,1,0,14'h10,8'hA0,1,0,0,0,0));
      tab[8]  = mkv(0, 0,1,0,0,1,1, 14'h10,14'h20, 8'hA0,8'hB0, mko(0,0,0,0,0,0,1,0,0,0,0));
      tab[9]  = mkv(0, 0,1,0,0,1,1, 14'h10,14'h20, 8'hA0,8'hB0, mko(0,1,1,0,14'h20,8'hB0,1,0,0,0,0));
      tab[10] = mkv(0, 0,1,0,0,0,0, 0,14'h20, 0,8'h55,  mko(0,1,0,1,14'h20,8'h00,1,0,0,0,0));
      tab[11] = mkv(0, 0,0,0,0,0,0, 0,0, 0,0,           mko(0,0,0,0,0,0,1,0,1,0,8'hB0));
      for (int i = 0; i < 12; i++) begin
         reset = tab[i].rst ? 1'b0 : 1'b1;
         set_in(tab[i].r0, tab[i].r1, tab[i].l0, tab[i].l1, tab[i].w0, tab[i].w1,
                tab[i].a0, tab[i].a1, tab[i].d0, tab[i].d1);
         cyc($sformatf("vec%0d", i), 1, tab[i].exp, 0);
      end
      reset = 1'b1;

      // ---- burst limit: both requesting continuously ----
      do_reset();
      set_in(1,1,0,0,0,0, 14'd1,14'd2, 0,0);
      for (int c = 0; c < 40; c++) begin
         cyc("burst", 0, '0, 1);
         code[c] = cur.g0 ? 1 : (cur.g1 ? 2 : 0);
      end
      f = -1;
      for (int c = 0; c < 40; c++) if (f < 0 && code[c] != 0) f = c;
      check_int("burst_first", f, 1);
      if (f < 0) f = 0;
      k = f; n0 = 0; n1 = 0; gaps = 0;
      while (k < 40 && code[k] == 1) begin n0++; k++; end
      while (k < 40 && code[k] == 2) begin n1++; k++; end
      for (int c = f; c < 40; c++) if (code[c] == 0) gaps++;
      check_int("burst_run0", n0, MB);
      check_int("burst_run1", n1, MB);
      check_int("burst_gaps", gaps, 0);
      check_int("burst_third", code[f + 2*MB], 1);

      // ---- lock holds ownership while req0 toggles ----
      do_reset();
      set_in(1,1,1,0,0,0, 0,0, 0,0); cyc("lock_idle", 0, '0, 1);
      cyc("lock_a", 0, '0, 1);        check_int("lock_a_g0", cur.g0, 1);
      set_in(0,1,1,0,0,0, 0,0, 0,0); cyc("lock_b", 0, '0, 1);
      check_int("lock_b_g1", cur.g1, 0); check_int("lock_b_busy", cur.busy, 1);
      set_in(1,1,1,0,0,0, 0,0, 0,0); cyc("lock_c", 0, '0, 1);
      check_int("lock_c_g0", cur.g0, 1); check_int("lock_c_g1", cur.g1, 0);
      set_in(0,1,0,0,0,0, 0,0, 0,0); cyc("lock_d", 0, '0, 1);
      check_int("lock_d_g1", cur.g1, 0);
      cyc("lock_e", 0, '0, 1);        check_int("lock_e_g1", cur.g1, 1);

      // ---- reset during an OWN1 read ----
      do_reset();
      set_in(0,1,0,0,0,0, 0,14'd3, 0,0); cyc("rr_idle", 0, '0, 1);
      cyc("rr_read", 0, '0, 1);
      check_int("rr_read_g1", cur.g1, 1); check_int("rr_read_rd", cur.rd, 1);
      reset = 1'b0;
      cyc("rr_rst", 1, '0, 1);
      reset = 1'b1;
      set_in(0,0,0,0,0,0, 0,0, 0,0);
      cyc("rr_after", 0, '0, 1);
      check_int("rr_after_rv1", cur.rv1, 0);

      // ---- random traffic against the model ----
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
         set_in($urandom_range(3) != 0, $urandom_range(3) != 0,
                $urandom_range(7) == 0, $urandom_range(7) == 0,
                $urandom_range(1) == 1, $urandom_range(1) == 1,
                14'($urandom_range(15)), 14'($urandom_range(15)),
                8'($urandom), 8'($urandom));
         cyc("rand", 0, '0, 1);
      end
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/res_mem_arbiter.md
RES_MEM_ARBITER -- requirements
Module: res_mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16: maximum consecutive granted transfers before forced handover to a pending peer.
REQ-002 Ports SHALL be exactly as follows, clock and reset first:
  clk  in  1  clock; reset reset, asynchronous, active-low; clock clk
  reset  in  1  asynchronous, active-low reset
  req0, req1  in  1  requester i wants a transfer this cycle
  lock0, lock1  in  1  requester i keeps ownership even with req low
  wr0, wr1  in  1  1 = write, 0 = read
  addr0, addr1  in  14  word address
  wdata0, wdata1  in  8  write data
  gnt0, gnt1  out  1  transfer of requester i performed this cycle
  rdata0, rdata1  out  8  registered read data
  rvalid0, rvalid1  out  1  rdata_i valid (one-cycle pulse)
  res_wr, res_rd  out  1  memory write / read strobe
  res_addr  out  14  memory address
  res_do  out  8  memory write data
  res_di  in  8  memory read data, valid in the same cycle as res_addr/res_rd
  busy  out  1  state != IDLE

Function
REQ-003 The FSM SHALL have states IDLE, OWN0 and OWN1, held in one registered state variable.
REQ-004 gnt_i SHALL equal (state==OWN_i) && req_i, combinationally; gnt0 and gnt1 SHALL never both be 1.
REQ-005 When gnt_i=1: res_addr=addr_i, res_wr=wr_i, res_rd=!wr_i, res_do=wr_i ? wdata_i : 0.
REQ-006 When no gnt is active: res_wr=0, res_rd=0, res_addr=0, res_do=0.
REQ-007 A read granted in cycle n SHALL produce rdata_i = res_di sampled at the cycle-n clock edge and rvalid_i=1 in cycle n+1 only; otherwise rvalid_i=0 and rdata_i holds its value.
REQ-008 IDLE transitions: only req_i → OWN_i; both req → the requester not equal to last_owner; none → IDLE.
REQ-009 IDLE SHALL perform no transfer, so first grant latency from IDLE is 1 cycle.
REQ-010 OWN_i transitions when req_i=0 and lock_i=0: req_j=1 → OWN_j (direct handover, no IDLE cycle); otherwise → IDLE.
REQ-011 OWN_i with lock_i=1 SHALL stay OWN_i regardless of req_j and burst count.
REQ-012 OWN_i with req_i=1, lock_i=0, req_j=1 and burst_cnt==MAX_BURST-1 SHALL move to OWN_j after the current transfer completes; the current transfer is granted.
REQ-013 burst_cnt SHALL clear on every state change, increment on each gnt cycle, and saturate at MAX_BURST-1.
REQ-014 last_owner SHALL update to i on every entry to OWN_i.
REQ-015 A requester's address, data and wr SHALL be sampled only while its gnt is 1; the arbiter SHALL NOT modify addresses (no auto-increment).
REQ-016 Simultaneous release by i and request by j SHALL hand over within one cycle, with no lost or duplicated transfer.

Reset
REQ-017 While reset=0: state=IDLE, last_owner=1 (req0 wins the first tie), burst_cnt=0, rdata0/1=0, rvalid0/1=0. All outputs SHALL then be 0: gnt, res_wr, res_rd, res_addr, res_do and busy.
REQ-018 Reset asserted mid-burst SHALL abort immediately. An in-flight rvalid SHALL be suppressed, and no transfer SHALL be issued until the first grant after reset release.

Structure
REQ-019 A shared package SHALL hold ADDR_W=14, DATA_W=8 and the state enum {IDLE, OWN0, OWN1}.
REQ-020 The block SHALL be a single module with no sub-modules. The tie-break/next-owner logic SHALL be a local function.

Verification
REQ-021 Scenario: req0 only; write addr 5 = 0x01, then read addr 5 → gnt0 on both cycles; rdata0=0x01 with rvalid0 on the cycle after the read.
REQ-022 Scenario: req0 and req1 rise together after reset → OWN0 first. After req0 drops, OWN1 on the next cycle, with no IDLE cycle between.
REQ-023 Scenario: req0 held for 40 cycles, lock0=0, req1 asserted from cycle 0 → req0 gets exactly 16 grants, then req1 is granted; ownership alternates every 16 grants.
REQ-024 Scenario: lock0=1 with req0 toggling 1,0,1 and req1=1 throughout → stays OWN0; gnt1=0 until lock0 falls.
REQ-025 Scenario: reset pulsed low during OWN1 while a read is pending → next cycle gnt=0, rvalid1=0, res_rd=0, busy=0.
REQ-026 Scenario: random req/lock/wr traffic against a memory model → gnt0&gnt1 never both 1; every read returns the last value written to that address.
